// File: rtl/ocr_pkg.sv
// Shared constants and state type for the OCR sampling front end.
package ocr_pkg;

    localparam int DATA_W             = 16;
    localparam int WIN_LOG2           = 4;
    localparam int WIN                = 1 << WIN_LOG2;
    localparam int SQ_W               = 32;
    localparam int ACC_W              = 36;
    localparam int DEFAULT_SAMPLE_DIV = 125000;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } ocr_state_t;

endpackage

// File: rtl/ocr_sample_strobe_gen.sv
// Free-running divider producing a one-cycle strobe every SAMPLE_DIV
// clk_master cycles. The strobe is high while the counter sits on its
// terminal value, so the first strobe follows SAMPLE_DIV cycles of reset.
module ocr_sample_strobe_gen
    import ocr_pkg::*;
#(
    parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV
) (
    input  logic clk_master,
    input  logic reset_n,
    output logic sample_stb
);

    localparam int              CNT_W    = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Divider counter: 0..SAMPLE_DIV-1, wrapping.
    always_ff @(posedge clk_master or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign sample_stb = (cnt == CNT_LAST);

endmodule

// File: rtl/ocr_sample_window.sv
// Sampling front end for the overcurrent relay: strobes the ADC, keeps a
// 16-sample sliding window of squares and reports the window mean-square
// with a pick-up comparison, 3 cycles after each strobe.
// Optional build macro OCR_PEAK_DETECT_EN adds peak_out, the largest sample
// captured during each full pass of the window write pointer.
module ocr_sample_window
    import ocr_pkg::*;
#(
    parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV
) (
    input  logic              clk_master,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] adc_data_in,
    input  logic [DATA_W-1:0] I_p,
    output logic              sample_stb,
    output logic              ms_valid,
    output logic [SQ_W-1:0]   ms_out,
    output logic              over_pickup,
    output logic              window_full
`ifdef OCR_PEAK_DETECT_EN
    ,
    output logic [DATA_W-1:0] peak_out
`endif
);

    localparam logic [WIN_LOG2-1:0] LAST_SLOT = WIN_LOG2'(WIN - 1);

    function automatic logic [SQ_W-1:0] square(input logic [DATA_W-1:0] v);
        return SQ_W'(v) * SQ_W'(v);
    endfunction

    // Floor division of the window sum by the window depth.
    function automatic logic [SQ_W-1:0] mean_sq(input logic [ACC_W-1:0] acc);
        return acc[ACC_W-1:WIN_LOG2];
    endfunction

    ocr_sample_strobe_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_strobe_gen (
        .clk_master (clk_master),
        .reset_n    (reset_n),
        .sample_stb (sample_stb)
    );

    logic [DATA_W-1:0]   win_buf [WIN];
    logic [WIN_LOG2-1:0] wr_ptr;
    logic [DATA_W-1:0]   x_p0, old_p0;
    logic                vld_p0;
    logic [SQ_W-1:0]     sq_new_p1, sq_old_p1;
    logic                vld_p1;
    logic [ACC_W-1:0]    sum_sq;
    logic [ACC_W-1:0]    sum_next;
    logic [SQ_W-1:0]     ms_next;
    logic [SQ_W-1:0]     ip_sq;
    logic                over_next;
    logic                emit;
    ocr_state_t          state;
    logic [WIN_LOG2-1:0] fill_cnt;

    // ---- stage p0: capture on strobe, swap the sample into the window ----
    // Capture the new sample and retire the oldest one from its slot.
    always_ff @(posedge clk_master or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0 <= 1'b0;
            x_p0   <= '0;
            old_p0 <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < WIN; i++) begin
                win_buf[i] <= '0;
            end
        end else begin
            vld_p0 <= sample_stb;
            if (sample_stb) begin
                x_p0            <= adc_data_in;
                old_p0          <= win_buf[wr_ptr];
                win_buf[wr_ptr] <= adc_data_in;
                wr_ptr          <= wr_ptr + WIN_LOG2'(1);
            end
        end
    end

    // ---- stage p1: square the incoming and outgoing samples ----
    // Register both squares so the accumulator update is a single add/sub.
    always_ff @(posedge clk_master or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1    <= 1'b0;
            sq_new_p1 <= '0;
            sq_old_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                sq_new_p1 <= square(x_p0);
                sq_old_p1 <= square(old_p0);
            end
        end
    end

    // ---- stage p2: accumulate, compare, publish ----
    // The running sum never goes negative: sq_old is always a term already in it.
    assign sum_next  = sum_sq + ACC_W'(sq_new_p1) - ACC_W'(sq_old_p1);
    assign ms_next   = mean_sq(sum_next);
    assign ip_sq     = square(I_p);
    assign over_next = (ms_next > ip_sq);
    assign emit      = vld_p1 && ((state == RUN) || (fill_cnt == LAST_SLOT));

    // Window-fill FSM plus the registered mean-square and pick-up outputs.
    always_ff @(posedge clk_master or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FILL;
            fill_cnt    <= '0;
            sum_sq      <= '0;
            ms_valid    <= 1'b0;
            ms_out      <= '0;
            over_pickup <= 1'b0;
            window_full <= 1'b0;
        end else begin
            ms_valid <= emit;
            if (vld_p1) begin
                sum_sq <= sum_next;
                if (state == FILL) begin
                    if (fill_cnt == LAST_SLOT) begin
                        state       <= RUN;
                        window_full <= 1'b1;
                    end else begin
                        fill_cnt <= fill_cnt + WIN_LOG2'(1);
                    end
                end
            end
            if (emit) begin
                ms_out      <= ms_next;
                over_pickup <= over_next;
            end
        end
    end

`ifdef OCR_PEAK_DETECT_EN
    function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [DATA_W-1:0] run_max, peak_hold;
    logic              pend_p0, pend_p1;

    // Track the per-pass maximum and release it alongside the slot-15 result.
    always_ff @(posedge clk_master or negedge reset_n) begin
        if (!reset_n) begin
            run_max   <= '0;
            peak_hold <= '0;
            pend_p0   <= 1'b0;
            pend_p1   <= 1'b0;
            peak_out  <= '0;
        end else begin
            pend_p0 <= sample_stb && (wr_ptr == LAST_SLOT);
            pend_p1 <= pend_p0;
            if (sample_stb) begin
                if (wr_ptr == LAST_SLOT) begin
                    peak_hold <= max_u(run_max, adc_data_in);
                    run_max   <= '0;
                end else begin
                    run_max <= max_u(run_max, adc_data_in);
                end
            end
            if (pend_p1) begin
                peak_out <= peak_hold;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ocr_sample_window.sv
// Bench for ocr_sample_window: stimulus pushes expected window results into
// a scoreboard queue; a monitor pops and compares on every ms_valid.
module tb_ocr_sample_window;

    localparam int SDIV = 8;

    logic        clk_master = 1'b0;
    logic        reset_n;
    logic [15:0] adc_data_in;
    logic [15:0] I_p;
    logic        sample_stb;
    logic        ms_valid;
    logic [31:0] ms_out;
    logic        over_pickup;
    logic        window_full;
`ifdef OCR_PEAK_DETECT_EN
    logic [15:0] peak_out;
`endif

    ocr_sample_window #(
        .SAMPLE_DIV (SDIV)
    ) dut (
        .clk_master  (clk_master),
        .reset_n     (reset_n),
        .adc_data_in (adc_data_in),
        .I_p         (I_p),
        .sample_stb  (sample_stb),
        .ms_valid    (ms_valid),
        .ms_out      (ms_out),
        .over_pickup (over_pickup),
        .window_full (window_full)
`ifdef OCR_PEAK_DETECT_EN
        ,
        .peak_out    (peak_out)
`endif
    );

    always #5 clk_master = ~clk_master;

    int cyc = 0;
    always @(posedge clk_master) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        longint ms;
        bit     ov;
        longint pk;
        int     cyc;
    } exp_t;

    exp_t   sb[$];
    longint hist[$];
    int     nstb     = 0;
    longint pk_exp   = 0;
    int     prev_stb = -1;

    logic [15:0] sine  [8] = '{16'd0, 16'd765, 16'd1414, 16'd1847,
                               16'd2000, 16'd1847, 16'd1414, 16'd765};
    logic [15:0] fault [8] = '{16'd0, 16'd1530, 16'd2828, 16'd3695,
                               16'd4000, 16'd3695, 16'd2828, 16'd1530};

    task automatic chk(input string name, input longint act, input longint req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference: mean of squares of the last 16 samples since reset, peak
    // of each aligned block of 16 samples since reset.
    task automatic model_strobe(input logic [15:0] x, input logic [15:0] ip);
        longint acc;
        longint m;
        longint ipv;
        exp_t   e;
        ipv = longint'(ip);
        hist.push_back(longint'(x));
        if (hist.size() > 16) void'(hist.pop_front());
        nstb++;
        if (nstb % 16 == 0) begin
            m = 0;
            foreach (hist[i]) if (hist[i] > m) m = hist[i];
            pk_exp = m;
        end
        if (nstb >= 16) begin
            acc = 0;
            foreach (hist[i]) acc += hist[i] * hist[i];
            e.ms  = acc / 16;
            e.ov  = (e.ms > ipv * ipv);
            e.pk  = pk_exp;
            e.cyc = cyc;
            sb.push_back(e);
        end
    endtask

    // Present x, wait (bounded) for the strobe that captures it, apply ip
    // for that strobe's comparison, then step one cycle past the capture.
    task automatic run_strobe(input logic [15:0] x, input logic [15:0] ip);
        bit seen;
        seen = 1'b0;
        adc_data_in = x;
        for (int i = 0; i < 4 * SDIV && !seen; i++) begin
            @(negedge clk_master);
            if (sample_stb) seen = 1'b1;
        end
        if (!seen) begin
            chk("strobe_timeout", 0, 1);
            return;
        end
        I_p = ip;
        if (prev_stb >= 0) chk("strobe_interval", longint'(cyc - prev_stb), SDIV);
        prev_stb = cyc;
        model_strobe(x, ip);
        @(negedge clk_master);
    endtask

    task automatic check_reset_outputs();
        chk("reset_sample_stb", longint'(sample_stb), 0);
        chk("reset_ms_valid", longint'(ms_valid), 0);
        chk("reset_ms_out", longint'(ms_out), 0);
        chk("reset_over_pickup", longint'(over_pickup), 0);
        chk("reset_window_full", longint'(window_full), 0);
`ifdef OCR_PEAK_DETECT_EN
        chk("reset_peak_out", longint'(peak_out), 0);
`endif
    endtask

    task automatic apply_reset();
        @(negedge clk_master);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs();
        sb.delete();
        hist.delete();
        nstb     = 0;
        pk_exp   = 0;
        prev_stb = -1;
        repeat (3) @(negedge clk_master);
        #2 reset_n = 1'b1;
    endtask

    // Monitor: every ms_valid must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_master);
            if (ms_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ms_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("ms_out", longint'(ms_out), e.ms);
                    chk("over_pickup", longint'(over_pickup), longint'(e.ov));
                    chk("window_full", longint'(window_full), 1);
                    chk("latency", longint'(cyc - e.cyc), 3);
`ifdef OCR_PEAK_DETECT_EN
                    chk("peak_out", longint'(peak_out), e.pk);
`endif
                end
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        adc_data_in = '0;
        I_p         = '0;
        apply_reset();

        // Constant 1000: first result on the 16th strobe, ms = 1000000.
        repeat (20) run_strobe(16'd1000, 16'd2000);
        // Nominal sine, below pick-up.
        for (int k = 0; k < 32; k++) run_strobe(sine[k % 8], 16'd2000);
        // Fault sine: mean-square climbs past I_p^2.
        for (int k = 0; k < 32; k++) run_strobe(fault[k % 8], 16'd2000);
        // Constant 500: per-pass peak drops to 500.
        for (int k = 0; k < 32; k++) run_strobe(16'd500, 16'd2000);
        // Full scale: no accumulator wrap; equality with I_p^2 is not over.
        for (int k = 0; k < 32; k++) run_strobe(16'hFFFF, 16'hFFFF);
        for (int k = 0; k < 4; k++) run_strobe(16'hFFFF, 16'hFFFE);

        // Reset while a result is in flight, then refill from scratch.
        for (int k = 0; k < 10; k++) run_strobe(16'($urandom_range(0, 4095)), 16'd1500);
        apply_reset();
        for (int k = 0; k < 10; k++) run_strobe(16'($urandom_range(0, 4095)), 16'd1500);
        chk("window_full_during_fill", longint'(window_full), 0);

        // Randomized data and pick-up settings.
        for (int k = 0; k < 40; k++)
            run_strobe(16'($urandom_range(0, 4095)), 16'($urandom_range(500, 3000)));
        for (int k = 0; k < 40; k++)
            run_strobe(16'($urandom), 16'($urandom));

        repeat (8) @(negedge clk_master);
        chk("scoreboard_drained", longint'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ocr_sample_window.md
Name: ocr_sample_window

Overview:
- Receive-side front end of the relay's sampling interface.
- Generates the periodic sample strobe from clk_master and captures adc_data_in on each strobe into a 16-deep sliding window.
- Maintains a running sum of squares and emits the window mean-square with a valid pulse.
- Compares the mean-square against I_p² and raises over_pickup; the downstream IDMT/trip timer consumes ms_out and over_pickup.

Parameters:
- SAMPLE_DIV, 125000, clk_master cycles between sample strobes (≥2).
- WIN_LOG2, 4, log2 of window depth; WIN = 16 samples (one 50 Hz cycle).
- DATA_W, 16, ADC sample and I_p width, unsigned.

Ports:
- clk_master  in  1  master clock, 100 MHz.
- reset_n  in  1  asynchronous active-low reset.
- adc_data_in  in  16  unsigned ADC sample, stable around the strobe.
- I_p  in  16  pick-up current setting, unsigned.
- sample_stb  out  1  one-cycle strobe; adc_data_in is captured on this cycle's rising edge.
- ms_valid  out  1  one-cycle pulse; ms_out and over_pickup are updated this cycle.
- ms_out  out  32  window mean-square = sum_sq >> WIN_LOG2 (floor).
- over_pickup  out  1  ms_out > I_p*I_p (strict), registered with ms_valid.
- window_full  out  1  high once WIN samples have been captured since reset.
- peak_out  out  16  only when OCR_PEAK_DETECT_EN is defined.

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0: sample_stb, ms_valid, ms_out, over_pickup, window_full, peak_out.
  - Divider counter, write pointer, fill counter, sum_sq and all buffer entries cleared to 0.
- Divider:
  - Counter runs 0..SAMPLE_DIV-1 and wraps.
  - sample_stb=1 during the cycle the counter equals SAMPLE_DIV-1.
  - The first strobe occurs SAMPLE_DIV cycles after reset release.
- Pipeline (strobe in cycle T):
  - T edge: sample x captured; old = buf[wr_ptr] read; buf[wr_ptr] <= x; wr_ptr increments modulo WIN.
  - T+1: sq_new = x*x and sq_old = old*old registered (32-bit each).
  - T+2: sum_sq <= sum_sq + sq_new - sq_old (36-bit, never negative).
  - T+3: ms_out and over_pickup registered; ms_valid=1 for exactly one cycle.
  - Fixed latency of 3 cycles strobe-to-valid.
- FSM:
  - FILL: fill counter increments per strobe; ms_valid is suppressed.
  - FILL→RUN when the 16th strobe's result reaches T+3. On that cycle window_full=1 and the first ms_valid fires.
  - RUN: ms_valid fires on every strobe. RUN is left only on reset.
- Comparison:
  - I_p*I_p is computed as 32-bit unsigned.
  - over_pickup = (ms_out > I_p²). Equality gives 0.
  - I_p is sampled in the T+2 cycle.
- Boundaries:
  - wr_ptr 15→0 wraps silently.
  - Full-scale samples (0xFFFF) must not overflow: 16*(0xFFFF)² < 2^36.
  - reset_n asserted mid-pipeline aborts in-flight data. No ms_valid is issued until the window refills.
- Inputs are assumed synchronous to clk_master; no CDC inside.

Optional Feature:
- Macro: OCR_PEAK_DETECT_EN.
- Defined:
  - peak_out is the maximum sample captured since the last wr_ptr wrap to 0.
  - peak_out updates alongside the ms_valid that follows the strobe writing slot 15.
  - The internal running max is cleared at the same point.
  - peak_out resets to 0.
- Undefined: peak_out port and logic are absent.

Decomposition:
- Package ocr_pkg:
  - Constants: DATA_W=16, WIN_LOG2=4, SQ_W=32, ACC_W=36, DEFAULT_SAMPLE_DIV=125000.
  - State enum {FILL, RUN}.
- Sub-module ocr_sample_strobe_gen: the divider counter and sample_stb. Reused by other timing blocks.

Test Plan:
- Reset, SAMPLE_DIV=8, adc=1000 constant → first ms_valid 3 cycles after 16th strobe; ms_out=1000000; window_full=1; over_pickup=0 with I_p=2000.
- Repeating 16-sample sine {0,765,1414,1847,2000,1847,1414,765}×2, I_p=2000 → ms_out=1999007, over_pickup=0 on every valid.
- Switch to fault sine {0,1530,2828,3695,4000,3695,2828,1530}×2 → ms_out rises monotonically to 7997877 after 16 fault strobes. over_pickup goes 1 on the first valid where ms_out>4000000.
- adc=0xFFFF for 32 strobes → ms_out=0xFFFE0001, no wrap; over_pickup=1 with I_p=0xFFFF? → 0 (equality).
- reset_n pulsed low after the 10th strobe → all outputs 0 immediately; window_full=0; next ms_valid only after 16 new strobes.
- OCR_PEAK_DETECT_EN: fault sine → peak_out=4000 after the first wrap; then constant 500 → peak_out=500 after the next wrap.
